fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the RV32I core.
- Owns the PC, drives the instruction-memory address and captures the returned instruction word the same cycle.
- Buffers {pc, inst} pairs in a DEPTH-entry FIFO that the decode stage drains with a valid/ready handshake.
- Supports redirect (branch/jal/jalr) with queue flush, temporary hold (load/store stall), permanent halt (ecall) and misaligned-target error.

Parameters:
- XLEN, 32, PC and instruction width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  synchronous reset, active-low.
- inst_addr  output  XLEN  current fetch PC to instruction memory; equals the pc register.
- inst  input  XLEN  instruction word for inst_addr, valid in the same cycle (combinational memory).
- redirect_valid  input  1  load a new PC and flush the queue.
- redirect_pc  input  XLEN  redirect target.
- fetch_hold  input  1  suppress push and PC advance this cycle; the queue keeps draining.
- halt_req  input  1  enter HALTED; sampled each cycle.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts the head entry.
- out_inst  output  XLEN  head instruction.
- out_pc  output  XLEN  head PC.
- count  output  $clog2(DEPTH+1)  occupied entries.
- fetch_idle  output  1  high when state is HALTED or ERROR and count==0.
- misalign_err  output  1  sticky; redirect_pc[1:0]!=0 was seen.

Behaviour:
- Reset (rst_b low at a rising edge):
  - pc=RESET_PC; read/write pointers=0; count=0; state=FETCH.
  - out_valid=0, misalign_err=0, fetch_idle=0.
  - out_inst and out_pc are don't-care while out_valid=0.
  - Reset mid-operation discards all entries and any pending redirect.
- States: FETCH, HALTED, ERROR.
  - FETCH -> HALTED when halt_req=1.
  - FETCH or HALTED -> ERROR on a misaligned redirect.
  - HALTED and ERROR leave only via reset.
- Push condition: state==FETCH && !fetch_hold && !redirect_valid && !halt_req && (count<DEPTH || pop).
  - On push: write {inst_addr, inst} at the write pointer; pc <= pc+4, modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
- Pop: out_valid && out_ready && !redirect_valid. Advances the read pointer.
- Full with a simultaneous pop: push is allowed; count is unchanged.
- Empty: out_valid=0. An empty push is not bypassed to the output; the entry becomes visible the cycle after it is written.
- count next = count + push - pop, except on redirect.
- Head outputs are driven combinationally from FIFO storage at the read pointer. out_valid = (count!=0).
- Redirect, aligned target, state FETCH or HALTED:
  - At that edge: pointers=0, count=0, pc <= redirect_pc. No push or pop.
  - State is unchanged; a simultaneous halt_req still moves FETCH -> HALTED.
  - Latency: the target appears on inst_addr 1 cycle after the redirect edge. It is pushed at the next edge (if push conditions hold) and is presented with out_valid=1 the cycle after that.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - Queue flushed; pc <= redirect_pc unchanged (not realigned).
  - misalign_err <= 1; state <= ERROR. No further pushes.
- Redirect in ERROR: ignored. No flush, no pc change.
- fetch_hold: pc is held and there is no push. Pop and redirect still act; redirect has priority over hold.
- HALTED: no pushes, pc frozen; the queue drains normally. fetch_idle rises the cycle count reaches 0.
- Priority at an edge: reset > redirect > halt_req (state transition) > push/pop.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally at DEPTH.

Test Plan:
- Reset with RESET_PC=0, inst=0x00000013 everywhere, out_ready=0 → inst_addr steps 0, 4, 8, 12; count reaches 4 and stays; inst_addr holds at 0x10; out_pc=0.
- Queue full, then out_ready=1 held → one entry pops and one pushes per cycle; count stays 4; out_pc sequence 0, 4, 8, …; no PC skipped or duplicated.
- Redirect to 0x100 with count=3 and out_ready=1 in the same cycle → next cycle count=0, out_valid=0, inst_addr=0x100; the following cycle out_valid=1, out_pc=0x100.
- fetch_hold=1 for 3 cycles with out_ready=1 and 3 entries queued → inst_addr frozen; count goes 3, 2, 1, 0; after release, fetch resumes at the held PC.
- halt_req pulse with 2 entries queued → no further pushes; count drains 2, 1, 0; fetch_idle=1 once count=0; a later redirect to 0x40 flushes and moves the PC but fetch_idle stays 1 with no pushes.
- Redirect to 0x102 → misalign_err=1 (sticky), fetch_idle=1, inst_addr=0x102; a subsequent redirect to 0x200 is ignored; rst_b low for one edge clears everything.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory port, control inputs and decode-side head handshake.
// slave = fetch_queue side, master = core/testbench side.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] inst_addr;
  logic [XLEN-1:0] inst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_hold;
  logic            halt_req;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;
  logic            fetch_idle;
  logic            misalign_err;

  modport slave (
    output inst_addr,
    input  inst,
    input  redirect_valid,
    input  redirect_pc,
    input  fetch_hold,
    input  halt_req,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output count,
    output fetch_idle,
    output misalign_err
  );

  modport master (
    input  inst_addr,
    output inst,
    output redirect_valid,
    output redirect_pc,
    output fetch_hold,
    output halt_req,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  count,
    input  fetch_idle,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, queues {pc, inst} pairs for decode; entries visible one cycle after fetch.
// Redirect flushes the queue; hold/halt stop fetching while decode keeps draining; a misaligned target latches ERROR.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_b,
  fetch_queue_if.slave   fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0]   PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HALTED = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_misalign;
  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [XLEN-1:0] r_mem_inst [DEPTH];

  logic w_misalign;
  logic w_redir;
  logic w_full;
  logic w_out_valid;
  logic w_pop;
  logic w_push;

  assign w_misalign  = (fq.redirect_pc[1:0] != 2'b00);
  // Redirects are dead once in ERROR: no flush and no PC change.
  assign w_redir     = fq.redirect_valid && (r_state != S_ERROR);
  assign w_full      = (r_count == FULL_CNT);
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && fq.out_ready && !fq.redirect_valid;
  assign w_push      = (r_state == S_FETCH) && !fq.fetch_hold && !fq.redirect_valid
                       && !fq.halt_req && (!w_full || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_redir && w_misalign) begin
          w_state_nxt = S_ERROR;
        end else if (fq.halt_req) begin
          w_state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        if (w_redir && w_misalign) begin
          w_state_nxt = S_ERROR;
        end
      end
      default: w_state_nxt = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_redir) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_pc    <= fq.redirect_pc;
        if (w_misalign) begin
          r_misalign <= 1'b1;
        end
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PTR_ONE;
          r_pc   <= r_pc + PC_STEP;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PTR_ONE;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: the pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (rst_b && w_push) begin
      r_mem_pc[r_wptr]   <= r_pc;
      r_mem_inst[r_wptr] <= fq.inst;
    end
  end

  assign fq.inst_addr    = r_pc;
  assign fq.out_valid    = w_out_valid;
  assign fq.out_pc       = r_mem_pc[r_rptr];
  assign fq.out_inst     = r_mem_inst[r_rptr];
  assign fq.count        = r_count;
  assign fq.fetch_idle   = ((r_state == S_HALTED) || (r_state == S_ERROR)) && !w_out_valid;
  assign fq.misalign_err = r_misalign;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: expected pops queued by the stimulus, checked by a negedge monitor.
module tb_fetch_queue;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'h5A5A_0013;

  logic        clk   = 1'b0;
  logic        rst_b = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .fq    (fq)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory: word is a function of its address.
  assign fq.inst = fq.inst_addr ^ K;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_ac(input string name, input logic [31:0] addr, input int cnt);
    chk({name, "_addr"}, fq.inst_addr, addr);
    chk({name, "_cnt"}, 32'(fq.count), 32'(cnt));
  endtask

  task automatic redirect(input logic [31:0] tgt);
    fq.redirect_valid = 1'b1;
    fq.redirect_pc    = tgt;
    tick();
    fq.redirect_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_b && fq.out_valid && fq.out_ready && !fq.redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got pc %h, expected no pop", fq.out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", fq.out_pc, mon_e);
        chk("pop_inst", fq.out_inst, mon_e ^ K);
      end
    end
  end

  initial begin
    fq.redirect_valid = 1'b0;
    fq.redirect_pc    = '0;
    fq.fetch_hold     = 1'b0;
    fq.halt_req       = 1'b0;
    fq.out_ready      = 1'b0;
    rst_b             = 1'b0;
    tick();
    tick();
    chk_ac("rst", 32'h0, 0);
    chk("rst_valid", 32'(fq.out_valid), 32'h0);
    chk("rst_misalign", 32'(fq.misalign_err), 32'h0);
    chk("rst_idle", 32'(fq.fetch_idle), 32'h0);
    rst_b = 1'b1;

    // Fill with decode stalled
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_ac("fill", 32'(4 * k), k);
    end
    tick();
    chk_ac("full", 32'h10, 4);
    chk("full_pc", fq.out_pc, 32'h0);
    chk("full_valid", 32'(fq.out_valid), 32'h1);

    // Streaming while full: one pop and one push each cycle
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
    fq.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("stream_cnt", 32'(fq.count), 32'h4);
    end
    fq.out_ready = 1'b0;
    chk("stream_addr", fq.inst_addr, 32'h30);
    chk("stream_head", fq.out_pc, 32'h20);

    // Get to count=3, then redirect with out_ready high
    exp_q.push_back(32'h20);
    fq.out_ready  = 1'b1;
    fq.fetch_hold = 1'b1;
    tick();
    chk_ac("pre_redir", 32'h30, 3);
    fq.fetch_hold = 1'b0;
    redirect(32'h100);
    fq.out_ready = 1'b0;
    chk_ac("redir", 32'h100, 0);
    chk("redir_valid", 32'(fq.out_valid), 32'h0);
    tick();
    chk_ac("redir_next", 32'h104, 1);
    chk("redir_valid2", 32'(fq.out_valid), 32'h1);
    chk("redir_pc", fq.out_pc, 32'h100);

    // Hold for 3 cycles while draining
    tick();
    tick();
    chk_ac("hold_pre", 32'h10C, 3);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    fq.fetch_hold = 1'b1;
    fq.out_ready  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_ac("hold", 32'h10C, 3 - k);
    end
    fq.fetch_hold = 1'b0;
    fq.out_ready  = 1'b0;
    tick();
    chk_ac("hold_rel", 32'h110, 1);
    chk("hold_rel_pc", fq.out_pc, 32'h10C);

    // Halt with 2 queued, drain, then redirect in HALTED
    tick();
    chk_ac("halt_pre", 32'h114, 2);
    fq.halt_req = 1'b1;
    tick();
    fq.halt_req = 1'b0;
    chk_ac("halt", 32'h114, 2);
    chk("halt_idle", 32'(fq.fetch_idle), 32'h0);
    exp_q.push_back(32'h10C);
    exp_q.push_back(32'h110);
    fq.out_ready = 1'b1;
    tick();
    chk_ac("halt_d1", 32'h114, 1);
    chk("halt_d1_idle", 32'(fq.fetch_idle), 32'h0);
    tick();
    chk_ac("halt_d0", 32'h114, 0);
    chk("halt_d0_idle", 32'(fq.fetch_idle), 32'h1);
    fq.out_ready = 1'b0;
    redirect(32'h40);
    chk_ac("halt_redir", 32'h40, 0);
    chk("halt_redir_idle", 32'(fq.fetch_idle), 32'h1);
    tick();
    tick();
    chk_ac("halt_frozen", 32'h40, 0);
    chk("halt_misalign", 32'(fq.misalign_err), 32'h0);

    // Misaligned redirect from FETCH with entries queued
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    chk_ac("rst2", 32'h0, 0);
    chk("rst2_idle", 32'(fq.fetch_idle), 32'h0);
    tick();
    tick();
    chk_ac("mis_pre", 32'h8, 2);
    redirect(32'h102);
    chk_ac("mis", 32'h102, 0);
    chk("mis_err", 32'(fq.misalign_err), 32'h1);
    chk("mis_idle", 32'(fq.fetch_idle), 32'h1);
    chk("mis_valid", 32'(fq.out_valid), 32'h0);
    tick();
    chk_ac("mis_nopush", 32'h102, 0);
    redirect(32'h200);
    chk_ac("mis_ignored", 32'h102, 0);
    chk("mis_sticky", 32'(fq.misalign_err), 32'h1);
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    chk_ac("rst3", 32'h0, 0);
    chk("rst3_err", 32'(fq.misalign_err), 32'h0);
    chk("rst3_idle", 32'(fq.fetch_idle), 32'h0);
    tick();
    chk_ac("rst3_fetch", 32'h4, 1);

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFFC);
    chk_ac("wrap_redir", 32'hFFFF_FFFC, 0);
    tick();
    chk_ac("wrap", 32'h0, 1);
    chk("wrap_pc", fq.out_pc, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    fq.out_ready = 1'b1;
    tick();
    chk_ac("wrap_s1", 32'h4, 1);
    tick();
    chk_ac("wrap_s2", 32'h8, 1);
    fq.out_ready = 1'b0;
    tick();

    chk("scoreboard_left", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
